// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared FSM encoding and segment constants for the score display
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LOAD    = 2'd2
    } state_t;

    localparam int MAX_SCORE = 99;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD to 7-segment decode, blank above 9
module seg7_decoder
    import score_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - sequential double-dabble and two-digit multiplexed 7-segment drive
module score_display_driver
    import score_pkg::*;
#(
    parameter int BW            = 7,
    parameter int REFRESH_W     = 10,
    parameter int BLANK_LEADING = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    dig_sel_o,
    output logic [3:0]    tens_o,
    output logic [3:0]    ones_o,
    output logic          busy_o
);

    localparam int SW = 8 + BW;
    localparam int CW = $clog2(BW + 1);
    localparam logic [BW-1:0] MAX_V = BW'(MAX_SCORE);

    state_t                 state;
    logic [BW-1:0]          last_val;
    logic [BW-1:0]          val_c;
    logic [SW-1:0]          scratch;
    logic [SW-1:0]          dabbled;
    logic [CW-1:0]          iter;
    logic [REFRESH_W-1:0]   refresh_cnt;
    logic [3:0]             digit;
    logic [6:0]             dec_seg;

    assign val_c = (value_i > MAX_V) ? MAX_V : value_i;

    // Add-3 correction on both BCD nibbles ahead of the shift; the clamp keeps tens below 10.
    always_comb begin
        dabbled = scratch;
        if (scratch[BW+3:BW] >= 4'd5)
            dabbled[BW+3:BW] = scratch[BW+3:BW] + 4'd3;
        if (scratch[BW+7:BW+4] >= 4'd5)
            dabbled[BW+7:BW+4] = scratch[BW+7:BW+4] + 4'd3;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            last_val <= '0;
            scratch  <= '0;
            iter     <= '0;
            tens_o   <= 4'd0;
            ones_o   <= 4'd0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (val_c != last_val) begin
                        last_val <= val_c;
                        scratch  <= {8'b0, val_c};
                        iter     <= '0;
                        busy_o   <= 1'b1;
                        state    <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    scratch <= dabbled << 1;
                    iter    <= iter + 1'b1;
                    if (iter == CW'(BW - 1))
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    tens_o <= scratch[BW+7:BW+4];
                    ones_o <= scratch[BW+3:BW];
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running refresh; the digit flips on the wrap from all-ones to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            refresh_cnt <= '0;
            dig_sel_o   <= 2'b01;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            if (&refresh_cnt)
                dig_sel_o <= {dig_sel_o[0], dig_sel_o[1]};
        end
    end

    assign digit = dig_sel_o[1] ? tens_o : ones_o;

    seg7_decoder u_seg7_decoder (
        .bcd_i (digit),
        .seg_o (dec_seg)
    );

    assign seg_o = ((BLANK_LEADING != 0) && dig_sel_o[1] && (tens_o == 4'd0)) ? SEG_BLANK : dec_seg;

endmodule

// File: tb/tb_score_display_driver.sv
// tb/tb_score_display_driver.sv - directed self-checking bench for score_display_driver
module tb_score_display_driver;

    localparam int BW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] value;
    logic [6:0]    seg;
    logic [1:0]    dig_sel;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    score_display_driver #(
        .BW            (BW),
        .REFRESH_W     (2),
        .BLANK_LEADING (1)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .value_i   (value),
        .seg_o     (seg),
        .dig_sel_o (dig_sel),
        .tens_o    (tens),
        .ones_o    (ones),
        .busy_o    (busy)
    );

    task automatic wait_sel(input logic [1:0] sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dig_sel === sel) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns on the first sample where busy has fallen after being high.
    task automatic wait_idle(output int busy_cycles, output bit ok);
        busy_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1)
                busy_cycles++;
            else if (busy_cycles > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit seen_busy;
        rst_n = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        checks++; if (tens !== 4'd0) begin errors++; $display("FAIL reset_tens got=%0d exp=0", tens); end
        checks++; if (ones !== 4'd0) begin errors++; $display("FAIL reset_ones got=%0d exp=0", ones); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dig_sel !== 2'b01) begin errors++; $display("FAIL reset_dig_sel got=%b exp=01", dig_sel); end
        checks++; if (seg !== 7'b0111111) begin errors++; $display("FAIL reset_seg got=%b exp=0111111", seg); end
        rst_n = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) seen_busy = 1'b1;
        end
        checks++; if (seen_busy) begin errors++; $display("FAIL reset_no_conversion got=busy exp=idle"); end
    endtask

    task automatic test_convert_42;
        int n;
        bit ok;
        value = 7'd42;
        wait_idle(n, ok);
        checks++; if (!ok || n != 8) begin errors++; $display("FAIL c42_busy_cycles got=%0d exp=8", n); end
        checks++; if (tens !== 4'd4) begin errors++; $display("FAIL c42_tens got=%0d exp=4", tens); end
        checks++; if (ones !== 4'd2) begin errors++; $display("FAIL c42_ones got=%0d exp=2", ones); end
        wait_sel(2'b01, ok);
        checks++; if (!ok || seg !== 7'b1011011) begin errors++; $display("FAIL c42_seg_ones got=%b exp=1011011", seg); end
        wait_sel(2'b10, ok);
        checks++; if (!ok || seg !== 7'b1100110) begin errors++; $display("FAIL c42_seg_tens got=%b exp=1100110", seg); end
    endtask

    task automatic test_blank_7;
        int n;
        bit ok;
        value = 7'd7;
        wait_idle(n, ok);
        checks++; if (!ok || tens !== 4'd0) begin errors++; $display("FAIL b7_tens got=%0d exp=0", tens); end
        checks++; if (ones !== 4'd7) begin errors++; $display("FAIL b7_ones got=%0d exp=7", ones); end
        wait_sel(2'b01, ok);
        checks++; if (!ok || seg !== 7'b0000111) begin errors++; $display("FAIL b7_seg_ones got=%b exp=0000111", seg); end
        wait_sel(2'b10, ok);
        checks++; if (!ok || seg !== 7'b0000000) begin errors++; $display("FAIL b7_seg_tens_blank got=%b exp=0000000", seg); end
        checks++; if (dig_sel !== 2'b10) begin errors++; $display("FAIL b7_dig_sel_kept got=%b exp=10", dig_sel); end
    endtask

    task automatic test_clamp_120;
        int n;
        bit ok;
        bit seen_busy;
        value = 7'd120;
        wait_idle(n, ok);
        checks++; if (!ok || tens !== 4'd9) begin errors++; $display("FAIL clamp_tens got=%0d exp=9", tens); end
        checks++; if (ones !== 4'd9) begin errors++; $display("FAIL clamp_ones got=%0d exp=9", ones); end
        wait_sel(2'b01, ok);
        checks++; if (!ok || seg !== 7'b1101111) begin errors++; $display("FAIL clamp_seg_ones got=%b exp=1101111", seg); end
        wait_sel(2'b10, ok);
        checks++; if (!ok || seg !== 7'b1101111) begin errors++; $display("FAIL clamp_seg_tens got=%b exp=1101111", seg); end
        value = 7'd99;
        seen_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) seen_busy = 1'b1;
        end
        checks++; if (seen_busy) begin errors++; $display("FAIL clamp_99_no_conversion got=busy exp=idle"); end
    endtask

    task automatic test_back_to_back;
        int n;
        bit ok;
        value = 7'd42;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid got=%b exp=1", busy); end
        value = 7'd57;
        wait_idle(n, ok);
        checks++; if (!ok || tens !== 4'd4 || ones !== 4'd2) begin errors++; $display("FAIL b2b_first got=%0d%0d exp=42", tens, ones); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reassert got=%b exp=1", busy); end
        wait_idle(n, ok);
        checks++; if (!ok || tens !== 4'd5 || ones !== 4'd7) begin errors++; $display("FAIL b2b_final got=%0d%0d exp=57", tens, ones); end
    endtask

    task automatic test_refresh;
        logic [1:0] prev;
        logic [1:0] cur;
        bit found;
        found = 1'b0;
        @(negedge clk);
        prev = dig_sel;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dig_sel !== prev) begin
                found = 1'b1;
                break;
            end
            prev = dig_sel;
        end
        cur = dig_sel;
        checks++; if (!found) begin errors++; $display("FAIL refresh_toggle_seen got=none exp=toggle"); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                checks++; if (dig_sel !== cur) begin errors++; $display("FAIL refresh_hold_%0d got=%b exp=%b", k, dig_sel, cur); end
            end else begin
                checks++; if (dig_sel !== {cur[0], cur[1]}) begin errors++; $display("FAIL refresh_period got=%b exp=%b", dig_sel, {cur[0], cur[1]}); end
            end
        end
    endtask

    task automatic test_reset_mid_conversion;
        int n;
        bit ok;
        value = 7'd80;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mrst_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b exp=0", busy); end
        checks++; if (dig_sel !== 2'b01) begin errors++; $display("FAIL mrst_dig_sel got=%b exp=01", dig_sel); end
        checks++; if (tens !== 4'd0 || ones !== 4'd0) begin errors++; $display("FAIL mrst_digits got=%0d%0d exp=00", tens, ones); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(n, ok);
        checks++; if (!ok || tens !== 4'd8 || ones !== 4'd0) begin errors++; $display("FAIL mrst_reconvert got=%0d%0d exp=80", tens, ones); end
    endtask

    initial begin
        rst_n = 1'b0;
        value = '0;
        test_reset;
        test_convert_42;
        test_blank_7;
        test_clamp_120;
        test_back_to_back;
        test_refresh;
        test_reset_mid_conversion;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
